user_clkdiv_mux: RTL and testbench

USER_CLKDIV_MUX -- requirements
Module: user_clkdiv_mux

---
 rtl/user_clkdiv_pkg.sv | 21 ++
 rtl/user_clkdiv_mux_core.sv | 49 ++++
 rtl/user_clkdiv_mux.sv | 128 ++++++++++++
 tb/tb_user_clkdiv_mux.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_clkdiv_pkg.sv
// user_clkdiv_pkg
// Shared definitions for the selectable divided-clock mux:
//   - state_t      : switch-control FSM states
//   - DEF_*        : default values for the top-level parameters
//   - PARK_W       : width of the park-phase cycle counter (PARK_CYC <= 255)
package user_clkdiv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,   // dividing on active_sel, accepting requests
        WAIT_LOW = 2'd1,   // dividing on the old channel until clk_out falls
        PARK     = 2'd2    // clk_out held low while the channel changes
    } state_t;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_PARK_CYC  = 2;
    localparam int DEF_RESET_SEL = 0;

    localparam int PARK_W = 8;

endpackage

// File: rtl/user_clkdiv_mux_core.sv
// user_clkdiv_core
// Half-period counter and divided-clock generator for one selected channel.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   park         : hold clk_out low and keep the counter at zero
//   cfg          : half-period minus one of the channel currently selected
//   clk_out      : registered divided clock
//   clk_en       : one-cycle pulse in the first cycle clk_out is high
//   toggle       : combinational, clk_out changes level on the coming edge
module user_clkdiv_core
    import user_clkdiv_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             park,
    input  logic [CNT_W-1:0] cfg,
    output logic             clk_out,
    output logic             clk_en,
    output logic             toggle
);

    logic [CNT_W-1:0] cnt;

    // '>=' rather than '==' so that lowering cfg below the running count
    // ends the phase on the next edge instead of wrapping the counter.
    assign toggle = !park && (cnt >= cfg);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else if (park) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else if (toggle) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            clk_en  <= ~clk_out;   // pulse only on the 0->1 change
        end else begin
            cnt     <= cnt + 1'b1;
            clk_en  <= 1'b0;
        end
    end

endmodule

// File: rtl/user_clkdiv_mux.sv
// user_clkdiv_mux
// Glitch-free selector between NUM_CH divided clocks derived from aclk.
// A request (sel/sel_valid/sel_ready) moves clk_out to another channel by
// finishing any high phase on the old channel, parking low for PARK_CYC
// cycles, then starting the new channel with a full low half-period.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   div_cfg      : per-channel half-period minus one, channel k at [k*CNT_W +: CNT_W]
//   sel, sel_valid, sel_ready : channel request handshake
//   clk_out, clk_en          : divided clock and its rising-edge enable pulse
//   active_sel, busy         : channel driving clk_out, switch in progress
//   switch_done, sel_err     : one-cycle completion / rejection pulses
module user_clkdiv_mux
    import user_clkdiv_pkg::*;
#(
    parameter  int NUM_CH    = DEF_NUM_CH,
    parameter  int CNT_W     = DEF_CNT_W,
    parameter  int PARK_CYC  = DEF_PARK_CYC,
    parameter  int RESET_SEL = DEF_RESET_SEL,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_CH*CNT_W-1:0] div_cfg,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic                    clk_out,
    output logic                    clk_en,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    busy,
    output logic                    switch_done,
    output logic                    sel_err
);

    localparam logic [SEL_W-1:0]  RST_SEL   = SEL_W'(RESET_SEL);
    localparam logic [SEL_W:0]    CH_LIMIT  = (SEL_W+1)'(NUM_CH);
    localparam logic [PARK_W-1:0] PARK_LAST = PARK_W'(PARK_CYC - 1);

    state_t              state;
    logic [SEL_W-1:0]    pend_sel;
    logic [PARK_W-1:0]   park_cnt;
    logic [CNT_W-1:0]    cfg_arr [NUM_CH];
    logic [CNT_W-1:0]    cfg_act;
    logic                toggle;
    logic                park;
    logic                accept;
    logic                sel_bad;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cfg
            assign cfg_arr[gi] = div_cfg[gi*CNT_W +: CNT_W];
        end
    endgenerate

    assign cfg_act   = cfg_arr[active_sel];
    assign park      = (state == PARK);
    assign sel_ready = (state == RUN) && !switch_done && !sel_err;
    assign accept    = sel_valid && sel_ready;
    assign sel_bad   = ({1'b0, sel} >= CH_LIMIT);

    user_clkdiv_core #(
        .CNT_W   (CNT_W)
    ) u_core (
        .aclk    (aclk),
        .areset  (areset),
        .park    (park),
        .cfg     (cfg_act),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .toggle  (toggle)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= RUN;
            pend_sel    <= RST_SEL;
            park_cnt    <= '0;
            active_sel  <= RST_SEL;
            busy        <= 1'b0;
            switch_done <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            sel_err     <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        if (sel_bad) begin
                            sel_err <= 1'b1;
                        end else if (sel == active_sel) begin
                            switch_done <= 1'b1;
                        end else begin
                            pend_sel <= sel;
                            busy     <= 1'b1;
                            park_cnt <= '0;
                            // The core still divides on the accepting edge, so
                            // decide on the level clk_out is about to take: a
                            // high phase that is just starting must run in full.
                            if (clk_out ^ toggle) begin
                                state <= WAIT_LOW;
                            end else begin
                                state <= PARK;
                            end
                        end
                    end
                end
                WAIT_LOW: begin
                    if (clk_out && toggle) begin
                        state <= PARK;
                    end
                end
                PARK: begin
                    if (park_cnt == PARK_LAST) begin
                        active_sel  <= pend_sel;
                        busy        <= 1'b0;
                        switch_done <= 1'b1;
                        state       <= RUN;
                    end else begin
                        park_cnt <= park_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_user_clkdiv_mux.sv
// Testbench for user_clkdiv_mux: directed scenarios plus a randomized
// request stream checked against a phase-length / latency reference model.
module tb_user_clkdiv_mux;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int PARK_CYC = 2;

    typedef struct {
        bit lvl;
        int len;
    } phase_t;

    logic                    aclk;
    logic                    areset;
    logic [NUM_CH*CNT_W-1:0] div_cfg;
    logic [1:0]              sel;
    logic                    sel_valid;
    logic                    sel_ready;
    logic                    clk_out;
    logic                    clk_en;
    logic [1:0]              active_sel;
    logic                    busy;
    logic                    switch_done;
    logic                    sel_err;

    // second instance with a non-power-of-two channel count to reach sel >= NUM_CH
    logic [5*CNT_W-1:0]      div_cfg2;
    logic [2:0]              sel2;
    logic                    sel_valid2;
    logic                    sel_ready2;
    logic                    clk_out2;
    logic                    clk_en2;
    logic [2:0]              active_sel2;
    logic                    busy2;
    logic                    switch_done2;
    logic                    sel_err2;

    int     cfg_tbl [NUM_CH] = '{0, 1, 3, 7};
    int     errors = 0;
    int     checks = 0;

    bit     prev_clk;
    bit     phase_end;
    bit     rose;
    int     run_len;
    int     ended_len;
    int     rises;
    int     ens;
    int     sd_count;
    phase_t phase_q [$];

    user_clkdiv_mux #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PARK_CYC(PARK_CYC), .RESET_SEL(0)
    ) dut (
        .aclk(aclk), .areset(areset), .div_cfg(div_cfg), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .clk_out(clk_out),
        .clk_en(clk_en), .active_sel(active_sel), .busy(busy),
        .switch_done(switch_done), .sel_err(sel_err)
    );

    user_clkdiv_mux #(
        .NUM_CH(5), .CNT_W(CNT_W), .PARK_CYC(PARK_CYC), .RESET_SEL(0)
    ) dut2 (
        .aclk(aclk), .areset(areset), .div_cfg(div_cfg2), .sel(sel2),
        .sel_valid(sel_valid2), .sel_ready(sel_ready2), .clk_out(clk_out2),
        .clk_en(clk_en2), .active_sel(active_sel2), .busy(busy2),
        .switch_done(switch_done2), .sel_err(sel_err2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int half(input int ch);
        return cfg_tbl[ch] + 1;
    endfunction

    // advance one cycle and record clk_out phase boundaries
    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
        phase_end = 1'b0;
        rose      = (clk_out === 1'b1) && !prev_clk;
        if ((clk_out === 1'b1) != prev_clk) begin
            phase_end = 1'b1;
            ended_len = run_len;
            phase_q.push_back('{lvl: prev_clk, len: run_len});
            run_len = 1;
        end else begin
            run_len++;
        end
        if (rose) rises++;
        if (clk_en === 1'b1) ens++;
        if (switch_done === 1'b1) sd_count++;
        prev_clk = (clk_out === 1'b1);
    endtask

    task automatic resync();
        prev_clk = (clk_out === 1'b1);
        run_len  = 1;
        rises    = 0;
        ens      = 0;
        sd_count = 0;
        phase_q.delete();
    endtask

    task automatic send_req(input logic [1:0] s, output bit ok);
        sel       = s;
        sel_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = (sel_ready === 1'b1);
            tick();
        end
        sel_valid = 1'b0;
        $display("tx req sel=%0d accepted=%0b active=%0d", s, ok, active_sel);
    endtask

    task automatic wait_edge(input bit lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            ok = phase_end && ((clk_out === 1'b1) == lvl);
        end
    endtask

    task automatic wait_done(input int bound, output int lat);
        lat = -1;
        for (int i = 1; i <= bound + 4 && lat < 0; i++) begin
            tick();
            if (switch_done === 1'b1) lat = i;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got=%b exp=0", clk_en); end
        checks++; if (active_sel !== 2'd0) begin errors++; $display("FAIL reset_active_sel got=%0d exp=0", active_sel); end
        checks++; if (busy !== 1'b0 || switch_done !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b err=%b exp=000", busy, switch_done, sel_err); end
        areset = 1'b0;
        resync();
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_sel_ready got=%b exp=1", sel_ready); end
        repeat (20) tick();
        foreach (phase_q[i]) begin
            checks++; if (phase_q[i].len != 1) begin errors++; $display("FAIL reset_ch0_phase idx=%0d got=%0d exp=1", i, phase_q[i].len); end
        end
        checks++; if (rises != 10) begin errors++; $display("FAIL reset_ch0_rises got=%0d exp=10", rises); end
        checks++; if (ens != 10) begin errors++; $display("FAIL reset_ch0_clk_en got=%0d exp=10", ens); end
    endtask

    task automatic test_wait_low();
        bit ok;
        int lat;
        int exp_len [4];
        bit exp_lvl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        send_req(2'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wl_accept_ch1 got=0 exp=1"); end
        wait_done(half(0) + PARK_CYC + 1, lat);
        checks++; if (lat < 1 || lat > half(0) + PARK_CYC + 1) begin errors++; $display("FAIL wl_lat_ch1 got=%0d exp<=%0d", lat, half(0) + PARK_CYC + 1); end
        checks++; if (active_sel !== 2'd1) begin errors++; $display("FAIL wl_active_ch1 got=%0d exp=1", active_sel); end
        wait_edge(1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wl_rise_timeout got=0 exp=1"); end
        phase_q.delete();
        sd_count = 0;
        send_req(2'd3, ok);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wl_busy got=%b exp=1", busy); end
        wait_done(half(1) + PARK_CYC + 1, lat);
        checks++; if (lat < 1 || lat > half(1) + PARK_CYC + 1) begin errors++; $display("FAIL wl_lat_ch3 got=%0d exp<=%0d", lat, half(1) + PARK_CYC + 1); end
        checks++; if (active_sel !== 2'd3) begin errors++; $display("FAIL wl_active_ch3 got=%0d exp=3", active_sel); end
        repeat (30) tick();
        // remaining old high phase, parked low + full new low, then steady ch3
        exp_len = '{half(1), PARK_CYC + half(3), half(3), half(3)};
        checks++; if (phase_q.size() < 4) begin errors++; $display("FAIL wl_phase_count got=%0d exp>=4", phase_q.size()); end
        for (int i = 0; i < 4 && i < phase_q.size(); i++) begin
            checks++; if (phase_q[i].lvl != exp_lvl[i] || phase_q[i].len != exp_len[i]) begin errors++; $display("FAIL wl_phase idx=%0d got=%0b/%0d exp=%0b/%0d", i, phase_q[i].lvl, phase_q[i].len, exp_lvl[i], exp_len[i]); end
        end
        checks++; if (sd_count != 1) begin errors++; $display("FAIL wl_done_count got=%0d exp=1", sd_count); end
    endtask

    task automatic test_direct_park();
        bit ok;
        int lat;
        wait_edge(1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dp_fall_timeout got=0 exp=1"); end
        phase_q.delete();
        send_req(2'd1, ok);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dp_busy got=%b exp=1", busy); end
        wait_done(PARK_CYC + 1, lat);
        checks++; if (lat < 1 || lat > PARK_CYC + 1) begin errors++; $display("FAIL dp_lat got=%0d exp<=%0d", lat, PARK_CYC + 1); end
        checks++; if (active_sel !== 2'd1) begin errors++; $display("FAIL dp_active got=%0d exp=1", active_sel); end
        repeat (12) tick();
        // one elapsed low cycle before accept, the park cycles, then a full ch1 low
        checks++; if (phase_q.size() < 3 || phase_q[0].lvl != 1'b0 || phase_q[0].len != 1 + PARK_CYC + half(1)) begin errors++; $display("FAIL dp_first_low got=%0d exp=%0d", (phase_q.size() > 0) ? phase_q[0].len : -1, 1 + PARK_CYC + half(1)); end
        foreach (phase_q[i]) begin
            checks++; if (phase_q[i].len < half(1)) begin errors++; $display("FAIL dp_min_phase idx=%0d got=%0d exp>=%0d", i, phase_q[i].len, half(1)); end
        end
    endtask

    task automatic test_noop_and_err();
        bit ok;
        bit c0;
        send_req(2'd1, ok);
        checks++; if (switch_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL noop_pulse got done=%b busy=%b exp done=1 busy=0", switch_done, busy); end
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL noop_ready_in_pulse got=%b exp=0", sel_ready); end
        tick();
        checks++; if (switch_done !== 1'b0 || sel_ready !== 1'b1) begin errors++; $display("FAIL noop_after got done=%b ready=%b exp done=0 ready=1", switch_done, sel_ready); end
        for (int s = 5; s <= 7; s++) begin
            sel2       = 3'(s);
            sel_valid2 = 1'b1;
            c0         = (clk_out2 === 1'b1);
            checks++; if (sel_ready2 !== 1'b1) begin errors++; $display("FAIL err_ready sel=%0d got=%b exp=1", s, sel_ready2); end
            tick();
            sel_valid2 = 1'b0;
            $display("tx err sel=%0d sel_err=%b active=%0d", s, sel_err2, active_sel2);
            checks++; if (sel_err2 !== 1'b1) begin errors++; $display("FAIL err_pulse sel=%0d got=%b exp=1", s, sel_err2); end
            checks++; if (active_sel2 !== 3'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL err_state sel=%0d got active=%0d busy=%b exp 0/0", s, active_sel2, busy2); end
            checks++; if ((clk_out2 === 1'b1) == c0) begin errors++; $display("FAIL err_clk_disturbed sel=%0d got=%b exp=%b", s, clk_out2, !c0); end
            tick();
            checks++; if (sel_err2 !== 1'b0) begin errors++; $display("FAIL err_pulse_len sel=%0d got=%b exp=0", s, sel_err2); end
        end
    endtask

    task automatic test_reset_mid_park();
        bit ok;
        wait_edge(1'b0, ok);
        send_req(2'd2, ok);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rp_busy got=%b exp=1", busy); end
        #2 areset = 1'b1;
        #1;
        checks++; if (clk_out !== 1'b0 || active_sel !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rp_async got clk=%b active=%0d busy=%b exp 0/0/0", clk_out, active_sel, busy); end
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        resync();
        repeat (10) tick();
        checks++; if (sd_count != 0) begin errors++; $display("FAIL rp_no_done got=%0d exp=0", sd_count); end
        checks++; if (active_sel !== 2'd0) begin errors++; $display("FAIL rp_active got=%0d exp=0", active_sel); end
        foreach (phase_q[i]) begin
            checks++; if (phase_q[i].len != half(0)) begin errors++; $display("FAIL rp_phase idx=%0d got=%0d exp=%0d", i, phase_q[i].len, half(0)); end
        end
    endtask

    task automatic test_random();
        bit         req_on = 1'b0;
        logic [1:0] req_sel = 2'd0;
        bit         will_accept;
        int         model_active = 0;
        bit         model_busy = 1'b0;
        int         sw_from = 0;
        int         sw_to = 0;
        int         wait_cnt = 0;
        int         bound = 0;
        int         min_h;
        bit         dirty = 1'b0;
        rises = 0;
        ens   = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!req_on && $urandom_range(0, 3) == 0) begin
                req_on  = 1'b1;
                req_sel = 2'($urandom_range(0, NUM_CH - 1));
            end
            sel         = req_sel;
            sel_valid   = req_on;
            will_accept = req_on && (sel_ready === 1'b1);
            if (model_busy) begin
                checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL rnd_ready_busy cyc=%0d got=%b exp=0", i, sel_ready); end
            end
            tick();
            if (phase_end) begin
                min_h = (half(sw_from) < half(sw_to)) ? half(sw_from) : half(sw_to);
                if (!dirty) begin
                    checks++; if (ended_len != half(model_active)) begin errors++; $display("FAIL rnd_phase cyc=%0d got=%0d exp=%0d", i, ended_len, half(model_active)); end
                end else begin
                    checks++; if (ended_len < min_h) begin errors++; $display("FAIL rnd_switch_phase cyc=%0d got=%0d exp>=%0d", i, ended_len, min_h); end
                end
                dirty = 1'b0;
            end
            checks++; if ((clk_en === 1'b1) != rose) begin errors++; $display("FAIL rnd_clk_en cyc=%0d got=%b exp=%b", i, clk_en, rose); end
            if (will_accept) begin
                req_on = 1'b0;
                $display("tx rnd cyc=%0d sel=%0d from=%0d", i, req_sel, model_active);
                if (int'(req_sel) == model_active) begin
                    checks++; if (switch_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rnd_noop cyc=%0d got done=%b busy=%b exp 1/0", i, switch_done, busy); end
                end else begin
                    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=1", i, busy); end
                    model_busy = 1'b1;
                    sw_from    = model_active;
                    sw_to      = int'(req_sel);
                    wait_cnt   = 0;
                    bound      = half(sw_from) + PARK_CYC + 1;
                end
            end else if (model_busy) begin
                wait_cnt++;
                if (switch_done === 1'b1) begin
                    checks++; if (int'(active_sel) != sw_to) begin errors++; $display("FAIL rnd_switch_to cyc=%0d got=%0d exp=%0d", i, active_sel, sw_to); end
                    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy_clear cyc=%0d got=%b exp=0", i, busy); end
                    model_active = sw_to;
                    model_busy   = 1'b0;
                end else if (wait_cnt > bound) begin
                    checks++; errors++;
                    $display("FAIL rnd_latency cyc=%0d got>%0d exp<=%0d", i, wait_cnt - 1, bound);
                    model_active = sw_to;
                    model_busy   = 1'b0;
                end
            end else begin
                checks++; if (switch_done !== 1'b0 || int'(active_sel) != model_active) begin errors++; $display("FAIL rnd_idle cyc=%0d got done=%b active=%0d exp 0/%0d", i, switch_done, active_sel, model_active); end
            end
            if (model_busy) dirty = 1'b1;
        end
        sel_valid = 1'b0;
        checks++; if (ens != rises || rises == 0) begin errors++; $display("FAIL rnd_clk_en_count got=%0d exp=%0d", ens, rises); end
    endtask

    initial begin
        areset     = 1'b1;
        div_cfg    = {8'd7, 8'd3, 8'd1, 8'd0};
        div_cfg2   = {8'd2, 8'd7, 8'd3, 8'd1, 8'd0};
        sel        = 2'd0;
        sel_valid  = 1'b0;
        sel2       = 3'd0;
        sel_valid2 = 1'b0;
        prev_clk   = 1'b0;
        run_len    = 1;
        rises      = 0;
        ens        = 0;
        sd_count   = 0;
        test_reset();
        test_wait_low();
        test_direct_park();
        test_noop_and_err();
        test_reset_mid_park();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
